// File: rtl/psum_drain_pkg.sv
// Shared types and helpers for the psum_drain output drain.
package psum_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Width of the beat index; at least one bit even for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psum_drain_buf.sv
// N_ROWS x WIDTH partial-sum buffer: parallel load, indexed read.
module psum_drain_buf #(
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [N_ROWS*WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [WIDTH-1:0]          rd_data
);

  logic [N_ROWS-1:0][WIDTH-1:0] mem;

  // Capture a whole column at once; reset wipes any partially drained set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem <= wr_data;
    end
  end

  // Row select for the current beat.
  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/psum_drain.sv
// Column output drain: parallel load of N_ROWS partial sums, serialized
// over a valid/ready stream, row 0 first.
// Optional midpoint bias compensation of truncated LSBs: PSUM_DRAIN_COMP_EN.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned N_ROWS     = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned IGNORE_BIT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [N_ROWS*WIDTH-1:0] load_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned IDX_W = idx_w(N_ROWS);

`ifdef PSUM_DRAIN_COMP_EN
  localparam bit COMP_ON = (IGNORE_BIT > 0);
`else
  localparam bit COMP_ON = 1'b0;
`endif

  // Bits [IGNORE_BIT-1:0] cleared, then bit IGNORE_BIT-1 set: no carry into upper bits.
  localparam logic [WIDTH-1:0] CLR_MASK = (IGNORE_BIT > 0) ? ((WIDTH'(1) << IGNORE_BIT) - WIDTH'(1)) : '0;
  localparam logic [WIDTH-1:0] SET_MASK = (IGNORE_BIT > 0) ? (WIDTH'(1) << (IGNORE_BIT - 1)) : '0;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             last_row, beat, load_en;
  logic [WIDTH-1:0] rd_data, comp_data;

  psum_drain_buf #(
    .N_ROWS (N_ROWS),
    .WIDTH  (WIDTH),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_en),
    .wr_data (load_data),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  // Handshake decode; load_ready also opens on the last-beat cycle for zero-bubble reloads.
  always_comb begin
    last_row   = (idx == IDX_W'(N_ROWS - 1));
    out_valid  = (state == DRAIN);
    busy       = (state == DRAIN);
    beat       = out_valid && out_ready;
    out_last   = out_valid && last_row;
    load_ready = (state == IDLE) || (beat && last_row);
    load_en    = load_valid && load_ready;
  end

  // Output word, optionally bias-compensated; held at zero outside DRAIN.
  always_comb begin
    comp_data = COMP_ON ? ((rd_data & ~CLR_MASK) | SET_MASK) : rd_data;
    out_data  = out_valid ? comp_data : '0;
  end

  // Next state and beat index; a load on the last beat wins over the return to IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (load_en) begin
      state_nxt = DRAIN;
      idx_nxt   = '0;
    end else if (beat) begin
      if (last_row) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end
  end

  // State and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

endmodule
